alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 One clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 alu_op  input  2  main-control ALU opcode: 00 load/store add, 01 branch subtract, 10 R-type (decode funct), 11 immediate OR.
REQ-005 funct  input  6  instruction bits [5:0]; used only when alu_op = 10.
REQ-006 a  input  32  operand A (register read data 1).
REQ-007 b  input  32  operand B (register read data 2 or sign-extended immediate).
REQ-008 branch  input  1  control Branch flag for the current instruction.
REQ-009 alu_ctrl  output  4  decoded ALU operation code; combinational.
REQ-010 result  output  32  registered ALU result.
REQ-011 zero  output  1  registered; 1 when the registered result equals 0.
REQ-012 overflow  output  1  registered signed overflow flag for ADD/SUB.
REQ-013 take_branch  output  1  registered AND of the branch flag and the zero flag.

Function
REQ-014 alu_ctrl decode, combinational from alu_op and funct:
- alu_op 00 -> 0010 (ADD).
- alu_op 01 -> 0110 (SUB).
- alu_op 11 -> 0001 (OR).
REQ-015 alu_op 10 decodes funct:
- 100000 and 100001 -> 0010 (ADD).
- 100010 and 100011 -> 0110 (SUB).
- 100100 -> 0000 (AND).
- 100101 -> 0001 (OR).
- 100110 -> 0011 (XOR).
- 100111 -> 1100 (NOR).
- 101010 -> 0111 (SLT).
- 101011 -> 1000 (SLTU).
- any other funct -> 1111 (invalid).
REQ-016 ALU operations:
- AND: a&b; OR: a|b; XOR: a^b; NOR: ~(a|b).
- ADD: a+b; SUB: a-b; both modulo 2^32 (carry/borrow discarded).
- SLT: 1 if $signed(a) < $signed(b), else 0.
- SLTU: 1 if a < b unsigned, else 0.
- Any other code (including 1111): result 0.
REQ-017 overflow is 1 only for:
- ADD: a and b have the same sign and the sum's sign differs.
- SUB: a and b have different signs and the difference's sign differs from a.
- All other operations: 0.
REQ-018 Latency is exactly 1 cycle: a, b, alu_op, funct and branch are sampled at a rising edge; result, zero, overflow and take_branch reflect them after that same edge.
REQ-019 zero is computed from the newly computed result, not the previous registered value.
REQ-020 take_branch = branch AND (new result == 0), registered in the same edge as result.
REQ-021 No handshake; a new operation is accepted every cycle, and outputs hold until the next edge.
REQ-022 alu_ctrl has no latency and does not depend on clk or rst.

Reset
REQ-023 On a rising edge with rst = 1: result = 0, zero = 0, overflow = 0, take_branch = 0; inputs are ignored.
REQ-024 Reset has priority over any operation in the same cycle; a mid-stream reset discards that cycle's operation.
REQ-025 The first edge with rst = 0 produces normal outputs for the inputs sampled at that edge.

Verification
REQ-026 alu_op=00, a=5, b=7 -> alu_ctrl=0010; after 1 edge result=12, zero=0, overflow=0.
REQ-027 alu_op=01, branch=1, a=b=0x0000_0010 -> alu_ctrl=0110; after 1 edge result=0, zero=1, take_branch=1. Same with branch=0 -> take_branch=0.
REQ-028 alu_op=10 with a=0xFFFF_FFFF (-1), b=1:
- funct 101010 -> result=1.
- funct 101011 -> result=0.
- funct 100111 -> result=0x0000_0000.
REQ-029 alu_op=10, funct=100000, a=0x7FFF_FFFF, b=1 -> result=0x8000_0000, overflow=1. funct 100010, a=0x8000_0000, b=1 -> result=0x7FFF_FFFF, overflow=1.
REQ-030 alu_op=10, funct=000111 -> alu_ctrl=1111, result=0, zero=1. alu_op=11, a=0xF0, b=0x0F -> result=0xFF.
REQ-031 Assert rst with valid operands applied -> all registered outputs 0 after the edge. Deassert -> the next edge yields the correct result.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU control decode plus single-cycle registered ALU execute stage.
//   clk         in   1   system clock, rising edge
//   rst         in   1   synchronous active-high reset
//   alu_op      in   2   main-control opcode (00 add, 01 sub, 10 R-type, 11 or)
//   funct       in   6   instruction funct field, used when alu_op = 10
//   a, b        in  32   operands
//   branch      in   1   branch control flag
//   alu_ctrl    out  4   decoded ALU operation, combinational
//   result      out 32   registered ALU result
//   zero        out  1   registered, result of this edge equals 0
//   overflow    out  1   registered signed overflow for ADD/SUB
//   take_branch out  1   registered branch AND zero
module alu_exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        branch,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        take_branch
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_INV  = 4'b1111;
    logic [3:0]  r_ctrl;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] res_next;
    logic        ovf_next;
    always_comb begin
        case (funct)
            6'b100000, 6'b100001: r_ctrl = OP_ADD;
            6'b100010, 6'b100011: r_ctrl = OP_SUB;
            6'b100100:            r_ctrl = OP_AND;
            6'b100101:            r_ctrl = OP_OR;
            6'b100110:            r_ctrl = OP_XOR;
            6'b100111:            r_ctrl = OP_NOR;
            6'b101010:            r_ctrl = OP_SLT;
            6'b101011:            r_ctrl = OP_SLTU;
            default:              r_ctrl = OP_INV;
        endcase
    end
    assign alu_ctrl = alu_op == 2'b00 ? OP_ADD :
                      alu_op == 2'b01 ? OP_SUB :
                      alu_op == 2'b11 ? OP_OR  : r_ctrl;
    assign sum  = a + b;
    assign diff = a - b;
    always_comb begin
        res_next = '0;
        ovf_next = 1'b0;
        case (alu_ctrl)
            OP_AND:  res_next = a & b;
            OP_OR:   res_next = a | b;
            OP_XOR:  res_next = a ^ b;
            OP_NOR:  res_next = ~(a | b);
            OP_ADD: begin
                res_next = sum;
                ovf_next = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            OP_SUB: begin
                res_next = diff;
                ovf_next = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            OP_SLT:  res_next = {31'b0, $signed(a) < $signed(b)};
            OP_SLTU: res_next = {31'b0, a < b};
            default: res_next = '0;
        endcase
    end
    // zero and take_branch look at this edge's result, not the held one
    always_ff @(posedge clk) begin
        if (rst) begin
            result      <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            take_branch <= 1'b0;
        end else begin
            result      <= res_next;
            zero        <= res_next == 32'd0;
            overflow    <= ovf_next;
            take_branch <= branch && (res_next == 32'd0);
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized scoreboard bench for alu_exec_unit against a plain-arithmetic model.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  alu_op = '0;
    logic [5:0]  funct = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        branch = 1'b0;
    logic [3:0]  alu_ctrl;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        take_branch;
    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        o;
        logic        t;
        string       tag;
    } exp_t;
    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;
    alu_exec_unit dut (
        .clk(clk), .rst(rst), .alu_op(alu_op), .funct(funct), .a(a), .b(b),
        .branch(branch), .alu_ctrl(alu_ctrl), .result(result), .zero(zero),
        .overflow(overflow), .take_branch(take_branch)
    );
    always #5 clk = ~clk;
    function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0001;
        if (f == 6'd32 || f == 6'd33) return 4'b0010;
        if (f == 6'd34 || f == 6'd35) return 4'b0110;
        if (f == 6'd36) return 4'b0000;
        if (f == 6'd37) return 4'b0001;
        if (f == 6'd38) return 4'b0011;
        if (f == 6'd39) return 4'b1100;
        if (f == 6'd42) return 4'b0111;
        if (f == 6'd43) return 4'b1000;
        return 4'b1111;
    endfunction
    function automatic void ref_exec(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] r, output logic o);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint s = 0;
        r = 32'd0;
        o = 1'b0;
        if (c == 4'b0010 || c == 4'b0110) begin
            s = (c == 4'b0010) ? sx + sy : sx - sy;
            r = s[31:0];
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        else if (c == 4'b0000) r = x & y;
        else if (c == 4'b0001) r = x | y;
        else if (c == 4'b0011) r = x ^ y;
        else if (c == 4'b1100) r = ~(x | y);
        else if (c == 4'b0111) r = (sx < sy) ? 32'd1 : 32'd0;
        else if (c == 4'b1000) r = (longint'(x) < longint'(y)) ? 32'd1 : 32'd0;
    endfunction
    task automatic issue(input string tag, input logic r_in, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] x, input logic [31:0] y, input logic br);
        exp_t e;
        logic [3:0] c;
        @(negedge clk);
        rst = r_in; alu_op = op; funct = f; a = x; b = y; branch = br;
        c = ref_ctrl(op, f);
        #1;
        vectors++;
        if (alu_ctrl !== c) begin
            miscompares++;
            $display("FAIL %s alu_ctrl: got %b expected %b", tag, alu_ctrl, c);
        end
        e.tag = tag;
        if (r_in) begin
            e.r = 0; e.z = 0; e.o = 0; e.t = 0;
        end else begin
            ref_exec(c, x, y, e.r, e.o);
            e.z = (e.r == 0);
            e.t = br && e.z;
        end
        q.push_back(e);
    endtask
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if (result !== e.r || zero !== e.z || overflow !== e.o || take_branch !== e.t) begin
                miscompares++;
                $display("FAIL %s outputs: got r=%h z=%b o=%b t=%b expected r=%h z=%b o=%b t=%b",
                         e.tag, result, zero, overflow, take_branch, e.r, e.z, e.o, e.t);
            end
        end
    end
    initial begin
        logic [5:0] fl [10] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43};
        logic [31:0] x, y;
        logic [5:0] f;
        int wait_cycles;
        issue("reset", 1, 2'b00, 6'd0, 32'd5, 32'd7, 1);
        issue("reset2", 1, 2'b01, 6'd0, 32'd3, 32'd3, 1);
        issue("add5_7", 0, 2'b00, 6'd0, 32'd5, 32'd7, 0);
        issue("beq_taken", 0, 2'b01, 6'd0, 32'h10, 32'h10, 1);
        issue("beq_nobranch", 0, 2'b01, 6'd0, 32'h10, 32'h10, 0);
        issue("slt_m1_1", 0, 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 0);
        issue("sltu_m1_1", 0, 2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd1, 0);
        issue("nor_m1_1", 0, 2'b10, 6'b100111, 32'hFFFF_FFFF, 32'd1, 1);
        issue("add_ovf", 0, 2'b10, 6'b100000, 32'h7FFF_FFFF, 32'd1, 0);
        issue("sub_ovf", 0, 2'b10, 6'b100010, 32'h8000_0000, 32'd1, 0);
        issue("invalid", 0, 2'b10, 6'b000111, 32'h1234, 32'h5678, 1);
        issue("ori", 0, 2'b11, 6'd0, 32'hF0, 32'h0F, 0);
        issue("xor_eq", 0, 2'b10, 6'b100110, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        issue("and", 0, 2'b10, 6'b100100, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
        issue("mid_reset", 1, 2'b00, 6'd0, 32'd100, 32'd200, 1);
        issue("after_reset", 0, 2'b00, 6'd0, 32'd100, 32'd200, 0);
        for (int i = 0; i < 400; i++) begin
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? x : 32'($urandom);
            if ($urandom_range(0, 5) == 0) x = {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'($urandom_range(0, 3))};
            f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fl[$urandom_range(0, 9)];
            issue("random", $urandom_range(0, 39) == 0, 2'($urandom), f, x, y, 1'($urandom));
        end
        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
